// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants, types and slot helper for the PmodI2S2 transmitter
package i2s_pkg;

  localparam int SMP_W     = 24;
  localparam int FRAME_LEN = 2048;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int SLOT_W    = 5;
  localparam int LEN_W     = 11;

  // Data occupies slots 1..24 of each 32-slot channel half (one-bit I2S delay).
  localparam int MSB_SLOT = 1;
  localparam int LSB_SLOT = 24;

  // Counter bits that are brought out directly as the DAC clocks.
  localparam int MCLK_BIT = 1;
  localparam int SCLK_BIT = 4;
  localparam int LRCK_BIT = 10;

  typedef logic signed [SMP_W-1:0] sample_t;
  typedef logic [CNT_W-1:0]        cnt_t;
  typedef logic [SLOT_W-1:0]       slot_t;
  typedef logic [LEN_W-1:0]        len_t;

  // Frame positions with special meaning.
  localparam cnt_t CNT_REQ_BUILD = cnt_t'(0);
  localparam cnt_t CNT_PRE_SWAP  = cnt_t'(FRAME_LEN - 2);
  localparam cnt_t CNT_SWAP      = cnt_t'(FRAME_LEN - 1);

  // Serial bit carried by a given slot of a channel half.
  function automatic logic slot_bit(input sample_t smp, input slot_t slot);
    slot_t idx;
    logic  b;
    b   = 1'b0;
    idx = '0;
    if (slot >= slot_t'(MSB_SLOT) && slot <= slot_t'(LSB_SLOT)) begin
      idx = slot_t'(LSB_SLOT) - slot;
      b   = smp[idx];
    end
    return b;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - frame counter and MCLK/SCLK/LRCK taps
module i2s_clkgen
  import i2s_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output cnt_t cnt_o,
  output logic mclk_o,
  output logic sclk_o,
  output logic lrck_o
);

  cnt_t cnt_q;
  cnt_t cnt_d;

  // Counter width equals log2 of the frame length, so it wraps 2047 -> 0 by itself.
  always_comb begin
    cnt_d = cnt_q + cnt_t'(1);
  end

  // Frame counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign mclk_o = cnt_q[MCLK_BIT];
  assign sclk_o = cnt_q[SCLK_BIT];
  assign lrck_o = cnt_q[LRCK_BIT];

endmodule

// File: rtl/pmod_i2s2_tx.sv
// rtl/pmod_i2s2_tx.sv - 24-bit mono I2S sink for the CS4344 that paces the synth (optional I2S_TX_VOLUME_EN)
module pmod_i2s2_tx
  import i2s_pkg::*;
#(
  parameter len_t LEN_RST = 11'd100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    note_trig,
  input  logic [LEN_W-1:0]        note_len,
  output logic                    syn_start,
  output logic                    syn_newnote,
  output logic [LEN_W-1:0]        syn_length,
  input  logic signed [SMP_W-1:0] din,
  input  logic                    din_valid,
  output logic                    underrun,
`ifdef I2S_TX_VOLUME_EN
  input  logic [2:0]              vol,
`endif
  output logic                    mclk,
  output logic                    sclk,
  output logic                    lrck,
  output logic                    sdout
);

  cnt_t cnt;

  i2s_clkgen u_clkgen (
    .clk    (clk),
    .rst    (rst),
    .cnt_o  (cnt),
    .mclk_o (mclk),
    .sclk_o (sclk),
    .lrck_o (lrck)
  );

  logic req_build;
  logic pre_swap;
  logic frame_end;
  logic slot_end;
  assign req_build = (cnt == CNT_REQ_BUILD);
  assign pre_swap  = (cnt == CNT_PRE_SWAP);
  assign frame_end = (cnt == CNT_SWAP);
  assign slot_end  = &cnt[SLOT_W-1:0];

  // ---------------------------------------------------------------- request
  logic note_pend_q, note_pend_d;
  len_t len_pend_q, len_pend_d;
  logic syn_start_q, syn_start_d;
  logic syn_newnote_q, syn_newnote_d;
  len_t syn_length_q, syn_length_d;
  logic pend_eff;
  len_t len_eff;

  // Build the request at cnt==0; a trigger in that same cycle is folded in.
  always_comb begin
    pend_eff      = note_pend_q | note_trig;
    len_eff       = note_trig ? note_len : len_pend_q;
    note_pend_d   = note_pend_q;
    len_pend_d    = len_pend_q;
    syn_length_d  = syn_length_q;
    syn_start_d   = req_build;
    syn_newnote_d = req_build & pend_eff;
    if (req_build) begin
      note_pend_d = 1'b0;
      if (pend_eff) begin
        syn_length_d = len_eff;
      end
    end else if (note_trig) begin
      note_pend_d = 1'b1;
      len_pend_d  = note_len;
    end
  end

  // Request and note-latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      note_pend_q   <= 1'b0;
      len_pend_q    <= '0;
      syn_start_q   <= 1'b0;
      syn_newnote_q <= 1'b0;
      syn_length_q  <= LEN_RST;
    end else begin
      note_pend_q   <= note_pend_d;
      len_pend_q    <= len_pend_d;
      syn_start_q   <= syn_start_d;
      syn_newnote_q <= syn_newnote_d;
      syn_length_q  <= syn_length_d;
    end
  end

  // ---------------------------------------------------------------- capture
  logic    outstanding_q, outstanding_d;
  logic    got_q, got_d;
  sample_t next_smp_q, next_smp_d;
  sample_t frame_smp_q, frame_smp_d;
  logic    underrun_q, underrun_d;
  logic    capture;
  sample_t cap_smp;

`ifdef I2S_TX_VOLUME_EN
  assign cap_smp = din >>> vol;
`else
  assign cap_smp = din;
`endif

  // Accept only the first sample after a request; swap it in at the frame end.
  always_comb begin
    capture       = din_valid & outstanding_q;
    outstanding_d = outstanding_q;
    got_d         = got_q;
    next_smp_d    = next_smp_q;
    frame_smp_d   = frame_smp_q;
    if (capture) begin
      outstanding_d = 1'b0;
      got_d         = 1'b1;
      next_smp_d    = cap_smp;
    end
    if (req_build) begin
      outstanding_d = 1'b1;
    end
    if (frame_end) begin
      if (got_q) begin
        frame_smp_d = next_smp_q;
      end
      got_d         = 1'b0;
      outstanding_d = 1'b0;
    end
    // Decided one cycle early so the registered pulse lands on cnt==2047.
    underrun_d = pre_swap & ~(got_q | capture);
  end

  // Capture and frame-sample registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= 1'b0;
      got_q         <= 1'b0;
      next_smp_q    <= '0;
      frame_smp_q   <= '0;
      underrun_q    <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      got_q         <= got_d;
      next_smp_q    <= next_smp_d;
      frame_smp_q   <= frame_smp_d;
      underrun_q    <= underrun_d;
    end
  end

  // ---------------------------------------------------------------- serializer
  logic  sdout_q, sdout_d;
  slot_t next_slot;

  // Load the next slot's bit at the end of each slot, i.e. on the SCLK falling edge.
  always_comb begin
    next_slot = cnt[SLOT_W +: SLOT_W] + slot_t'(1);
    sdout_d   = sdout_q;
    if (slot_end) begin
      sdout_d = slot_bit(frame_smp_q, next_slot);
    end
  end

  // Serial data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sdout_q <= 1'b0;
    end else begin
      sdout_q <= sdout_d;
    end
  end

  assign syn_start   = syn_start_q;
  assign syn_newnote = syn_newnote_q;
  assign syn_length  = syn_length_q;
  assign underrun    = underrun_q;
  assign sdout       = sdout_q;

endmodule

// File: tb/tb_pmod_i2s2_tx.sv
// tb/tb_pmod_i2s2_tx.sv - frame-level self-checking bench for pmod_i2s2_tx
module tb_pmod_i2s2_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               note_trig;
  logic [10:0]        note_len;
  logic               syn_start;
  logic               syn_newnote;
  logic [10:0]        syn_length;
  logic signed [23:0] din;
  logic               din_valid;
  logic               underrun;
  logic               mclk, sclk, lrck, sdout;
`ifdef I2S_TX_VOLUME_EN
  logic [2:0]         vol;
  logic [2:0]         p_vol;
`endif

  pmod_i2s2_tx dut (
    .clk         (clk),
    .rst         (rst),
    .note_trig   (note_trig),
    .note_len    (note_len),
    .syn_start   (syn_start),
    .syn_newnote (syn_newnote),
    .syn_length  (syn_length),
    .din         (din),
    .din_valid   (din_valid),
    .underrun    (underrun),
`ifdef I2S_TX_VOLUME_EN
    .vol         (vol),
`endif
    .mclk        (mclk),
    .sclk        (sclk),
    .lrck        (lrck),
    .sdout       (sdout)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cur_frame = 0;
  int cur_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s frame %0d cycle %0d: got %h expected %h", tag, cur_frame, cur_cyc, got, exp);
    end
  endtask

  // Reference model state, updated once per frame.
  logic [23:0] m_cur;
  logic [10:0] m_len, m_plen;
  bit          m_pend;

  // Per-frame stimulus plan.
  int          p_trig;
  logic [10:0] p_len;
  int          p_nv;
  int          p_vc[4];
  logic [23:0] p_vd[4];
  int          p_abort;

  task automatic model_reset();
    m_cur = 24'h0; m_len = 11'd100; m_plen = 11'd0; m_pend = 1'b0;
  endtask

  task automatic clear_plan();
    p_trig = -1; p_len = 11'd0; p_nv = 0; p_abort = -1;
`ifdef I2S_TX_VOLUME_EN
    p_vol = 3'd0;
`endif
  endtask

  task automatic add_valid(input int c, input logic [23:0] d);
    p_vc[p_nv] = c; p_vd[p_nv] = d; p_nv++;
  endtask

  function automatic logic [23:0] scaled(input logic [23:0] d);
    logic signed [23:0] s;
    s = d;
`ifdef I2S_TX_VOLUME_EN
    s = s >>> p_vol;
`endif
    return s;
  endfunction

  task automatic check_reset_outputs();
    check("rst_pins", {mclk, sclk, lrck, sdout, syn_start, syn_newnote, underrun}, 7'b0);
    check("rst_len", syn_length, 11'd100);
  endtask

  // Runs one frame from the cnt==0 cycle; entered and left at a negedge.
  task automatic run_frame();
    bit          nn, cap, v;
    logic [10:0] nlen, cb;
    logic [23:0] cap_val, vd;
    logic [31:0] word;
    logic [6:0]  ep;
    int          cap_cyc, idx;
    nn      = m_pend || (p_trig == 0);
    nlen    = (p_trig == 0) ? p_len : m_plen;
    cap     = 1'b0;
    cap_cyc = 4096;
    cap_val = 24'h0;
    for (int i = 0; i < p_nv; i++) begin
      if (p_vc[i] >= 1 && p_vc[i] <= 2046 && p_vc[i] < cap_cyc) begin
        cap = 1'b1; cap_cyc = p_vc[i]; cap_val = scaled(p_vd[i]);
      end
    end
    // One channel half: delay bit, 24 sample bits MSB first, 7 pad bits.
    word = {1'b0, m_cur, 7'b0};
`ifdef I2S_TX_VOLUME_EN
    vol = p_vol;
`endif
    for (int c = 0; c < 2048; c++) begin
      cur_cyc   = c;
      cb        = 11'(c);
      note_trig = (c == p_trig);
      note_len  = (c == p_trig) ? p_len : 11'($urandom);
      v  = 1'b0;
      vd = 24'($urandom);
      for (int i = 0; i < p_nv; i++) begin
        if (!v && p_vc[i] == c) begin v = 1'b1; vd = p_vd[i]; end
      end
      din_valid = v;
      din       = vd;
      idx = 31 - int'(cb[9:5]);
      ep  = {cb[1], cb[4], cb[10], word[idx], c == 1, (c == 1) && nn, (c == 2047) && !cap};
      check("pins", {mclk, sclk, lrck, sdout, syn_start, syn_newnote, underrun}, ep);
      check("len", syn_length, (c >= 1 && nn) ? nlen : m_len);
      if (c == p_abort) begin
        rst = 1'b1; note_trig = 1'b0; din_valid = 1'b0;
        @(negedge clk);
        cur_cyc = -1;
        check_reset_outputs();
        rst = 1'b0;
        model_reset();
        cur_frame++;
        return;
      end
      @(negedge clk);
    end
    if (nn) begin m_pend = 1'b0; m_len = nlen; end
    if (p_trig > 0) begin m_pend = 1'b1; m_plen = p_len; end
    if (cap) m_cur = cap_val;
    cur_frame++;
  endtask

  task automatic random_plan();
    int n;
    clear_plan();
    if ($urandom_range(2, 0) == 0) begin
      p_trig = $urandom_range(2047, 0);
      p_len  = 11'($urandom);
    end
    n = $urandom_range(3, 0);
    for (int i = 0; i < n; i++) add_valid($urandom_range(2046, 0), 24'($urandom));
`ifdef I2S_TX_VOLUME_EN
    p_vol = 3'($urandom);
`endif
  endtask

  initial begin
    rst = 1'b1; note_trig = 1'b0; note_len = 11'd0; din = 24'sd0; din_valid = 1'b0;
`ifdef I2S_TX_VOLUME_EN
    vol = 3'd0;
`endif
    model_reset();
    clear_plan();
    repeat (3) @(negedge clk);
    cur_cyc = -1;
    check_reset_outputs();
    rst = 1'b0;

    // Steady 0x800001 returned 5 cycles after each request.
    for (int f = 0; f < 3; f++) begin
      clear_plan(); add_valid(6, 24'h800001); run_frame();
    end
    // New note with length 200 mid-frame, then a plain request.
    clear_plan(); p_trig = 500; p_len = 11'd200; add_valid(6, 24'h0A5A5A); run_frame();
    clear_plan(); add_valid(30, 24'h3C0FF0); run_frame();
    clear_plan(); add_valid(1, 24'h000777); run_frame();
    // Trigger in the request-building cycle.
    clear_plan(); p_trig = 0; p_len = 11'($urandom); add_valid(1000, 24'h654321); run_frame();
    // Underrun replays the previous sample.
    clear_plan(); add_valid(2046, 24'h123456); run_frame();
    clear_plan(); run_frame();
    clear_plan(); add_valid(100, 24'hABCDEF); run_frame();
    // Early arrival ignored, first valid kept, duplicate ignored.
    clear_plan(); add_valid(0, 24'h555555); add_valid(10, 24'h000010); add_valid(20, 24'h7FFFFF); run_frame();
    clear_plan(); add_valid(6, 24'h000001); run_frame();
`ifdef I2S_TX_VOLUME_EN
    clear_plan(); p_vol = 3'd2; add_valid(6, 24'hFFFF00); run_frame();
    clear_plan(); add_valid(6, 24'h000002); run_frame();
`endif
    for (int f = 0; f < 5; f++) begin
      random_plan(); run_frame();
    end
    // Mid-frame reset aborts the pending note and the outstanding request.
    clear_plan(); p_trig = 300; p_len = 11'd55; add_valid(6, 24'h1FFFFF); p_abort = 900; run_frame();
    clear_plan(); add_valid(0, 24'h777777); run_frame();
    clear_plan(); add_valid(40, 24'hC00003); run_frame();
    for (int f = 0; f < 3; f++) begin
      random_plan(); run_frame();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
